unidad_fetch: RTL and testbench

Instruction fetch stage placed directly upstream of `unidad_control`. It owns the program counter, drives a request/ready instruction-memory port, and holds the fetched word in an instruction register. It splits that word into the fields the control unit and register file consume (`cond`, `op`, `funct`, `rd`, `rn`, `rm`, `imm24`). It advances or redirects the PC using `pc_src` and `branch_target` returned by the control unit and datapath.

---
 rtl/unidad_fetch.sv | 109 ++++++++++
 tb/tb_unidad_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_fetch.sv
// Instruction fetch stage: owns the PC, issues memory reads over a req/ready port,
// holds the fetched word and splits it into fields for the control unit.
module unidad_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,

    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,

    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rn,
    output logic [3:0]        rd,
    output logic [3:0]        rm,
    output logic [23:0]       imm24,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic [ADDR_W-1:0] redirect_pc;
    logic              unused_target_bits;

    assign redirect_pc        = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // pc_src/branch_target matter only on the accepting edge in ISSUE.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_d          = pc_src ? redirect_pc : pc_q + ADDR_W'(4);
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only, so async reset clears them at once.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign imem_addr   = pc_q;

    assign instr       = instr_q;
    assign cond        = instr_q[31:28];
    assign op          = instr_q[27:26];
    assign funct       = instr_q[25:20];
    assign rn          = instr_q[19:16];
    assign rd          = instr_q[15:12];
    assign rm          = instr_q[3:0];
    assign imm24       = instr_q[23:0];
    assign pc          = pc_q;
    assign pc_plus8    = pc_q + ADDR_W'(8);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_unidad_fetch.sv
// Scoreboard bench for unidad_fetch: stimulus queues the expected issued instruction,
// a monitor checks it when the consumer accepts.
module tb_unidad_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm24;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic [31:0] fetch_count;

    logic        rst_w;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [3:0]  cond_w;
    logic [1:0]  op_w;
    logic [5:0]  funct_w;
    logic [3:0]  rn_w;
    logic [3:0]  rd_w;
    logic [3:0]  rm_w;
    logic [23:0] imm24_w;
    logic [31:0] pc_w;
    logic [31:0] pc_plus8_w;
    logic [31:0] fetch_count_w;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] plus8;
        logic [31:0] count;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_word;
    logic [31:0] cur_pc;

    always #5 clk = ~clk;

    unidad_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_src(pc_src), .branch_target(branch_target),
        .instr(instr), .cond(cond), .op(op), .funct(funct),
        .rn(rn), .rd(rd), .rm(rm), .imm24(imm24),
        .pc(pc), .pc_plus8(pc_plus8), .fetch_count(fetch_count)
    );

    unidad_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ready(1'b1), .imem_rdata(32'h0000_0001),
        .instr_valid(instr_valid_w), .instr_ready(1'b1),
        .pc_src(1'b0), .branch_target(32'h0),
        .instr(instr_w), .cond(cond_w), .op(op_w), .funct(funct_w),
        .rn(rn_w), .rd(rd_w), .rm(rm_w), .imm24(imm24_w),
        .pc(pc_w), .pc_plus8(pc_plus8_w), .fetch_count(fetch_count_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_accept: got pc %h, expected no issue", pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("acc_pc", pc, mon_e.pc);
                check("acc_instr", instr, mon_e.word);
                check("acc_pc_plus8", pc_plus8, mon_e.plus8);
                check("acc_fetch_count", fetch_count, mon_e.count);
                check("acc_cond", {28'h0, cond}, {28'h0, mon_e.word[31:28]});
                check("acc_rd", {28'h0, rd}, {28'h0, mon_e.word[15:12]});
                check("acc_imm24", {8'h0, imm24}, {8'h0, mon_e.word[23:0]});
            end
        end
    end

    task automatic do_fetch(input logic [31:0] word, input int waits, input bit noise,
                            input logic [31:0] e_pc, input logic [31:0] e_p8,
                            input logic [31:0] e_cnt);
        int   fetch_cycles;
        exp_t e;
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("req_seen", {31'h0, imem_req}, 32'h1);
        check("imem_addr", imem_addr, e_pc);
        fetch_cycles = 0;
        if (noise) begin
            pc_src        = 1'b1;
            branch_target = 32'h0000_0555;
        end
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hBAD0_0000;
            if (imem_req === 1'b1) fetch_cycles++;
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        if (imem_req === 1'b1) fetch_cycles++;
        e.pc = e_pc; e.word = word; e.plus8 = e_p8; e.count = e_cnt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        imem_ready    = 1'b0;
        imem_rdata    = 32'hDEAD_BEEF;
        pc_src        = 1'b0;
        branch_target = 32'h0;
        check("fetch_cycles", fetch_cycles, waits + 1);
        check("valid_rise", {31'h0, instr_valid}, 32'h1);
        check("req_fall", {31'h0, imem_req}, 32'h0);
        check("instr_capture", instr, word);
        cur_word = word;
        cur_pc   = e_pc;
    endtask

    task automatic do_issue(input int holds, input bit take, input logic [31:0] tgt);
        instr_ready = 1'b0;
        for (int i = 0; i < holds; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'h0, instr_valid}, 32'h1);
            check("hold_instr", instr, cur_word);
            check("hold_pc", pc, cur_pc);
            check("hold_rm", {28'h0, rm}, {28'h0, cur_word[3:0]});
            check("hold_req", {31'h0, imem_req}, 32'h0);
        end
        instr_ready   = 1'b1;
        pc_src        = take;
        branch_target = tgt;
        @(posedge clk); #1;
        instr_ready   = 1'b0;
        pc_src        = 1'b0;
        branch_target = 32'h0;
        check("valid_fall", {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; rst_w = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
        cur_word = 32'h0; cur_pc = 32'h0;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_req", {31'h0, imem_req}, 32'h0);
        end
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        rst = 1'b1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);

        do_fetch(32'hE280_1005, 0, 1'b0, 32'h0, 32'h8, 32'h0);
        check("f_cond", {28'h0, cond}, 32'hE);
        check("f_op", {30'h0, op}, 32'h0);
        check("f_funct", {26'h0, funct}, 32'h28);
        check("f_rn", {28'h0, rn}, 32'h0);
        check("f_rd", {28'h0, rd}, 32'h1);
        check("f_rm", {28'h0, rm}, 32'h5);
        check("f_imm24", {8'h0, imm24}, 32'h0080_1005);
        do_issue(0, 1'b0, 32'h0);

        do_fetch(32'hE081_2003, 0, 1'b0, 32'h4, 32'hC, 32'h1);
        do_issue(0, 1'b0, 32'h0);
        do_fetch(32'hE3A0_000F, 0, 1'b0, 32'h8, 32'h10, 32'h2);
        do_issue(0, 1'b0, 32'h0);
        do_fetch(32'hE153_0004, 0, 1'b0, 32'hC, 32'h14, 32'h3);
        do_issue(0, 1'b0, 32'h0);
        check("count_after4", fetch_count, 32'h4);
        check("pc_after4", imem_addr, 32'h10);

        do_fetch(32'hEA00_003F, 1, 1'b1, 32'h10, 32'h18, 32'h4);
        do_issue(0, 1'b1, 32'h0000_0103);

        do_fetch(32'hE591_2000, 3, 1'b0, 32'h100, 32'h108, 32'h5);
        do_issue(2, 1'b0, 32'h0);

        check("pre_rst_addr", imem_addr, 32'h104);
        imem_ready = 1'b0;
        @(posedge clk); #1;
        check("wait_req", {31'h0, imem_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_count", fetch_count, 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(posedge clk); #1;
            check("late_ready_instr", instr, 32'h0);
        end
        rst = 1'b1;
        check("post_rst_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        check("idle_ready_ignored", instr, 32'h0);
        check("idle_ready_valid", {31'h0, instr_valid}, 32'h0);
        imem_ready = 1'b0;
        do_fetch(32'h1234_5678, 0, 1'b0, 32'h0, 32'h8, 32'h0);
        do_issue(1, 1'b0, 32'h0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", exp_q.size(), 32'h0);

        rst_w = 1'b1;
        for (int i = 0; i < 20 && instr_valid_w !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("wrap_valid", {31'h0, instr_valid_w}, 32'h1);
        check("wrap_pc", pc_w, 32'hFFFF_FFFC);
        check("wrap_pc_plus8", pc_plus8_w, 32'h0000_0004);
        @(posedge clk); #1;
        check("wrap_pc_next", pc_w, 32'h0);
        check("wrap_addr_next", imem_addr_w, 32'h0);
        check("wrap_count", fetch_count_w, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
